// File: rtl/hdc_pkg.sv
// Shared types and default sizes for the HDC cleanup datapath.
// Default hypervector and codebook dimensions live here.
package hdc_pkg;

    localparam int DEF_VECTOR_LEN  = 32;
    localparam int DEF_NUM_ENTRIES = 16;
    localparam int DEF_IDX_W       = $clog2(DEF_NUM_ENTRIES);
    localparam int DEF_SCORE_W     = $clog2(DEF_VECTOR_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } cleanup_state_t;

    typedef logic [DEF_SCORE_W-1:0] score_t;
    typedef logic [DEF_IDX_W-1:0]   idx_t;

endpackage

// File: rtl/hdc_popcount.sv
// XNOR similarity: counts matching dimensions of two bipolar vectors.
// Purely combinational; shared with the other similarity units.
module hdc_popcount
    import hdc_pkg::*;
#(
    parameter int VECTOR_LEN = DEF_VECTOR_LEN,
    parameter int SCORE_W    = $clog2(VECTOR_LEN + 1)
) (
    input  logic [VECTOR_LEN-1:0] query,
    input  logic [VECTOR_LEN-1:0] entry,
    output logic [SCORE_W-1:0]    score
);

    logic [VECTOR_LEN-1:0] match;

    assign match = ~(query ^ entry);

    always_comb begin
        score = '0;
        for (int i = 0; i < VECTOR_LEN; i++) begin
            score = score + SCORE_W'(match[i]);
        end
    end

endmodule

// File: rtl/hdc_cleanup_search.sv
// Codebook cleanup: scans all entries, returns best XNOR-popcount match.
// Optional HDC_CLEANUP_EARLY_EXIT_EN stops the scan on a perfect match.
module hdc_cleanup_search
    import hdc_pkg::*;
#(
    parameter int VECTOR_LEN  = DEF_VECTOR_LEN,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int SCORE_W     = $clog2(VECTOR_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  query_valid,
    output logic                  query_ready,
    input  logic [VECTOR_LEN-1:0] query_vec,
    output logic                  cb_rd_en,
    output logic [IDX_W-1:0]      cb_rd_addr,
    input  logic [VECTOR_LEN-1:0] cb_rd_data,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [IDX_W-1:0]      result_idx,
    output logic [SCORE_W-1:0]    result_score
);

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_ENTRIES - 1);

    cleanup_state_t        state;
    logic [VECTOR_LEN-1:0] query_q;
    logic                  pipe_valid;
    logic [IDX_W-1:0]      pipe_idx;
    logic [SCORE_W-1:0]    best_score;
    logic [IDX_W-1:0]      best_idx;
    logic [SCORE_W-1:0]    score;
    logic                  upd;
    logic                  hit;
    logic [SCORE_W-1:0]    nxt_score;
    logic [IDX_W-1:0]      nxt_idx;

    hdc_popcount #(
        .VECTOR_LEN (VECTOR_LEN),
        .SCORE_W    (SCORE_W)
    ) u_popcount (
        .query (query_q),
        .entry (cb_rd_data),
        .score (score)
    );

    // Entry 0 always seeds the best; later entries must beat it strictly.
    assign upd = pipe_valid
               && (state == SCAN || state == DRAIN)
               && (pipe_idx == '0 || score > best_score);

    assign nxt_score = upd ? score : best_score;
    assign nxt_idx   = upd ? pipe_idx : best_idx;

`ifdef HDC_CLEANUP_EARLY_EXIT_EN
    assign hit = pipe_valid
              && state == SCAN
              && score == SCORE_W'(VECTOR_LEN);
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            query_q      <= '0;
            query_ready  <= 1'b0;
            cb_rd_en     <= 1'b0;
            cb_rd_addr   <= '0;
            pipe_valid   <= 1'b0;
            pipe_idx     <= '0;
            best_score   <= '0;
            best_idx     <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_score <= '0;
        end else begin
            pipe_valid <= cb_rd_en;
            pipe_idx   <= cb_rd_addr;
            best_score <= nxt_score;
            best_idx   <= nxt_idx;
            unique case (state)
                IDLE: begin
                    if (query_valid && query_ready) begin
                        query_q     <= query_vec;
                        query_ready <= 1'b0;
                        cb_rd_en    <= 1'b1;
                        cb_rd_addr  <= '0;
                        state       <= SCAN;
                    end else begin
                        query_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    // A perfect hit drops the read issued this cycle.
                    if (hit) begin
                        cb_rd_en     <= 1'b0;
                        result_valid <= 1'b1;
                        result_idx   <= nxt_idx;
                        result_score <= nxt_score;
                        state        <= DONE;
                    end else if (cb_rd_addr == LAST_ADDR) begin
                        cb_rd_en <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        cb_rd_addr <= cb_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    result_valid <= 1'b1;
                    result_idx   <= nxt_idx;
                    result_score <= nxt_score;
                    state        <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        query_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_cleanup_search.sv
// Directed bench for hdc_cleanup_search with a codebook memory model
// and a scoreboard of expected results, aware of HDC_CLEANUP_EARLY_EXIT_EN.
module tb_hdc_cleanup_search;
    import hdc_pkg::*;

    localparam int VL = DEF_VECTOR_LEN;
    localparam int NE = DEF_NUM_ENTRIES;
    localparam int IW = $clog2(NE);
    localparam int SW = $clog2(VL + 1);
`ifdef HDC_CLEANUP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [IW-1:0] idx;
        logic [SW-1:0] score;
        int            lat;
        int            reads;
    } exp_t;

    exp_t sb[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          query_valid = 1'b0;
    logic          result_ready = 1'b0;
    logic [VL-1:0] query_vec = '0;
    logic [VL-1:0] cb_rd_data = '0;
    logic          query_ready;
    logic          cb_rd_en;
    logic          result_valid;
    logic [IW-1:0] cb_rd_addr;
    logic [IW-1:0] result_idx;
    logic [SW-1:0] result_score;
    logic [VL-1:0] mem [NE];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int last_rd = -1;
    int t_acc = 0;
    int rd_base = 0;

    hdc_cleanup_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_vec    (query_vec),
        .cb_rd_en     (cb_rd_en),
        .cb_rd_addr   (cb_rd_addr),
        .cb_rd_data   (cb_rd_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_idx   (result_idx),
        .result_score (result_score)
    );

    always #5 clk = ~clk;

    // Codebook memory: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cb_rd_en) begin
            cb_rd_data <= mem[cb_rd_addr];
            rd_cnt     <= rd_cnt + 1;
            last_rd    <= cyc;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(logic [VL-1:0] q);
        exp_t e;
        int   s;
        e.idx   = '0;
        e.score = '0;
        e.lat   = NE + 2;
        e.reads = NE;
        for (int i = 0; i < NE; i++) begin
            s = $countones(~(q ^ mem[i]));
            if (i == 0 || s > int'(e.score)) begin
                e.idx   = IW'(i);
                e.score = SW'(s);
            end
            if (EARLY && s == VL) begin
                e.lat   = 3 + i;
                e.reads = (i + 2 < NE) ? i + 2 : NE;
                break;
            end
        end
        return e;
    endfunction

    // Called at a negedge; the handshake lands on the next posedge.
    task automatic send(logic [VL-1:0] q);
        int n = 0;
        while (query_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("query_ready_wait", query_ready, 1);
        if (query_ready !== 1'b1) return;
        query_vec   = q;
        query_valid = 1'b1;
        t_acc       = cyc;
        rd_base     = rd_cnt;
        sb.push_back(model(q));
        @(negedge clk);
        query_valid = 1'b0;
    endtask

    task automatic get_result(string tag, int hold, bit poke);
        exp_t e;
        int   n = 0;
        while (result_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
        if (result_valid !== 1'b1 || sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_lat"}, cyc - t_acc, e.lat);
        chk({tag, "_idx"}, 32'(result_idx), 32'(e.idx));
        chk({tag, "_score"}, 32'(result_score), 32'(e.score));
        chk({tag, "_reads"}, rd_cnt - rd_base, e.reads);
        chk({tag, "_last_rd"}, last_rd - t_acc, e.reads);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                query_valid = 1'b1;
                query_vec   = ~query_vec;
            end
            @(negedge clk);
            chk({tag, "_hold_valid"}, result_valid, 1);
            chk({tag, "_hold_idx"}, 32'(result_idx), 32'(e.idx));
            chk({tag, "_hold_score"}, 32'(result_score), 32'(e.score));
            chk({tag, "_hold_qrdy"}, query_ready, 0);
            chk({tag, "_hold_rden"}, cb_rd_en, 0);
        end
        query_valid  = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({tag, "_qrdy_after"}, query_ready, 1);
        chk({tag, "_valid_after"}, result_valid, 0);
    endtask

    initial begin
        logic [VL-1:0] b;

        // Reset values while rst_n is low.
        #1;
        chk("rst_qrdy", query_ready, 0);
        chk("rst_rden", cb_rd_en, 0);
        chk("rst_addr", 32'(cb_rd_addr), 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_idx", 32'(result_idx), 0);
        chk("rst_score", 32'(result_score), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_qrdy_pre", query_ready, 0);
        @(negedge clk);
        chk("rel_qrdy", query_ready, 1);

        // 1: replicated-nibble codebook, exact match at entry 5.
        for (int i = 0; i < NE; i++) mem[i] = {8{4'(i)}};
        send(mem[5]);
        get_result("t1", 0, 1'b0);
        chk("t1_idx_const", 32'(result_idx), 5);
        chk("t1_score_const", 32'(result_score), VL);

        // 2: entries 3 and 9 tie at 30 matches; lowest wins.
        b = 32'hA5A5_F00F;
        for (int i = 0; i < NE; i++) mem[i] = ~b;
        mem[0]  = b ^ 32'h0000_00FF;
        mem[3]  = b ^ 32'h0000_0003;
        mem[9]  = b ^ 32'hC000_0000;
        mem[12] = b ^ 32'h0000_0007;
        send(b);
        get_result("t2", 0, 1'b0);
        chk("t2_idx_const", 32'(result_idx), 3);
        chk("t2_score_const", 32'(result_score), 30);

        // 3: complement query scores zero everywhere.
        for (int i = 0; i < NE; i++) mem[i] = 32'h1234_5678;
        send(~mem[0]);
        get_result("t3", 0, 1'b0);
        chk("t3_score_zero", 32'(result_score), 0);

        // 3b: all-ones everywhere scores the full length.
        for (int i = 0; i < NE; i++) mem[i] = '1;
        send('1);
        get_result("t3b", 0, 1'b0);
        chk("t3b_score_max", 32'(result_score), VL);

        // 4: consumer stalls 10 cycles while a query is offered.
        for (int i = 0; i < NE; i++) mem[i] = 32'h0F0F_0F0F ^ (32'h1 << i);
        send(mem[11] ^ 32'h0001_0000);
        get_result("t4", 10, 1'b1);
        rd_base = rd_cnt;
        repeat (3) @(negedge clk);
        chk("t4_no_search", rd_cnt - rd_base, 0);
        chk("t4_no_result", result_valid, 0);

        // 5: reset mid-scan abandons the search.
        send(mem[4]);
        repeat (6) @(negedge clk);
        chk("t5_scanning", cb_rd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rden", cb_rd_en, 0);
        chk("t5_valid", result_valid, 0);
        chk("t5_qrdy", query_ready, 0);
        chk("t5_addr", 32'(cb_rd_addr), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_partial", result_valid, 0);
        send(mem[4]);
        get_result("t5b", 0, 1'b0);

        // 6: perfect match at 2 (and again at 7).
        for (int i = 0; i < NE; i++) mem[i] = 32'h0F0F_0F0F ^ (32'h1 << i);
        mem[2] = 32'hDEAD_BEEF;
        mem[7] = 32'hDEAD_BEEF;
        send(32'hDEAD_BEEF);
        get_result("t6", 0, 1'b0);
        chk("t6_idx_const", 32'(result_idx), 2);
        chk("t6_lat_const", cyc - t_acc, EARLY ? 6 : NE + 3);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
